// File: rtl/triple_sample_collector.sv
// Samples din three times, SAMPLE_GAP clocks apart, and holds a/b/c with valid until ack.
// Optional registered majority output enabled by defining TSC_VOTE_OUT_EN.
module triple_sample_collector #(
  parameter int SAMPLE_GAP = 4,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic din,
  input  logic ack,
  output logic busy,
  output logic valid,
  output logic a,
  output logic b,
  output logic c
`ifdef TSC_VOTE_OUT_EN
  ,
  output logic maj
`endif
);

  typedef enum logic [1:0] {IDLE, S1, S2, DONE} state_t;

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(SAMPLE_GAP - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             a_q, b_q, c_q;
`ifdef TSC_VOTE_OUT_EN
  logic             maj_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      c_q     <= 1'b0;
`ifdef TSC_VOTE_OUT_EN
      maj_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= din;
            cnt_q   <= '0;
            state_q <= S1;
          end
        end
        S1: begin
          if (cnt_q == GAP_LAST) begin
            b_q     <= din;
            cnt_q   <= '0;
            state_q <= S2;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S2: begin
          if (cnt_q == GAP_LAST) begin
            c_q     <= din;
            cnt_q   <= '0;
            state_q <= DONE;
`ifdef TSC_VOTE_OUT_EN
            // Vote uses the incoming c, since c_q only updates on this same edge.
            maj_q   <= (a_q & b_q) | (b_q & din) | (a_q & din);
`endif
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (ack) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = (state_q != IDLE);
  assign valid = (state_q == DONE);
  assign a     = a_q;
  assign b     = b_q;
  assign c     = c_q;
`ifdef TSC_VOTE_OUT_EN
  assign maj   = maj_q;
`endif

endmodule
